// File: rtl/i2c_monitor.sv
// rtl/i2c_monitor.sv - passive I2C bus monitor emitting one decoded record per transaction
// Optional address filter ports are enabled by defining I2C_MON_ADDR_FILTER_EN.
module i2c_monitor #(
    parameter int DATA_WIDTH  = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scl,
    input  logic                  sda,
`ifdef I2C_MON_ADDR_FILTER_EN
    input  logic [6:0]            filter_addr,
    input  logic                  filter_on,
`endif
    output logic                  txn_valid,
    output logic                  txn_rw,
    output logic [6:0]            txn_slave_addr,
    output logic [7:0]            txn_data_addr,
    output logic [DATA_WIDTH-1:0] txn_data,
    output logic                  txn_nack,
    output logic                  txn_err,
    output logic                  busy
);
    localparam logic [7:0] NB = 8'(DATA_WIDTH / 8);

    typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, BYTE, BYTE_ACK} state_t;
    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_s, sda_s, scl_p, sda_p;

    logic [2:0]            bit_cnt;
    logic [6:0]            shift;
    logic                  bit_smp, armed;
    logic                  w_rw, addr_done, daddr_seen, w_nack, w_err, pend_nack;
    logic [6:0]            w_addr;
    logic [7:0]            w_daddr, pay_cnt;
    logic [DATA_WIDTH-1:0] w_data;

    logic scl_hi, scl_rise, scl_fall, bit_fall, start_det, stop_det;
    logic in_ack, in_shift, byte_done, ack_err, addr_only, closing, rec_err, emit;
    logic [7:0] byte_val;

    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_p    <= 1'b1;
            sda_p    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
            scl_p    <= scl_s;
            sda_p    <= sda_s;
        end
    end

    // START/STOP need scl stable high across both samples, so a joint scl+sda edge is plain data
    assign scl_hi    = scl_s & scl_p;
    assign scl_rise  = scl_s & ~scl_p;
    assign scl_fall  = ~scl_s & scl_p;
    assign start_det = scl_hi & sda_p & ~sda_s;
    assign stop_det  = scl_hi & ~sda_p & sda_s;
    // A bit is committed on the falling edge, so the rise preceding a START/STOP never counts
    assign bit_fall  = scl_fall & armed;

    assign in_ack    = (state == ADDR_ACK) || (state == BYTE_ACK);
    assign in_shift  = (state == ADDR) || (state == BYTE);
    assign byte_done = in_shift && bit_fall && (bit_cnt == 3'd7);
    assign byte_val  = {shift, bit_smp};
    assign ack_err   = in_ack && scl_hi && (sda_s != sda_p);
    assign addr_only = (state == BYTE) && addr_done && !w_rw && daddr_seen
                       && (pay_cnt == 8'd0) && (bit_cnt == 3'd0);
    assign closing   = (state != IDLE) && (stop_det || (start_det && !addr_only));
    assign rec_err   = w_err || ack_err || (in_shift && (bit_cnt != 3'd0)) || (pay_cnt != NB);
`ifdef I2C_MON_ADDR_FILTER_EN
    assign emit      = closing && (!filter_on || (w_addr == filter_addr));
`else
    assign emit      = closing;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (start_det) begin
            state_nxt = ADDR;
        end else if (stop_det) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                ADDR:     if (byte_done) state_nxt = ADDR_ACK;
                ADDR_ACK: if (bit_fall)  state_nxt = BYTE;
                BYTE:     if (byte_done) state_nxt = BYTE_ACK;
                BYTE_ACK: if (bit_fall)  state_nxt = BYTE;
                default:  state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            txn_valid <= 1'b0; txn_rw <= 1'b0; txn_slave_addr <= '0; txn_data_addr <= '0;
            txn_data <= '0; txn_nack <= 1'b0; txn_err <= 1'b0; busy <= 1'b0;
            bit_cnt <= '0; shift <= '0; bit_smp <= 1'b0; armed <= 1'b0;
            w_rw <= 1'b0; addr_done <= 1'b0; daddr_seen <= 1'b0; w_nack <= 1'b0;
            w_err <= 1'b0; pend_nack <= 1'b0; w_addr <= '0; w_daddr <= '0;
            pay_cnt <= '0; w_data <= '0;
        end else begin
            txn_valid <= 1'b0;
            if (emit) begin
                txn_valid      <= 1'b1;
                txn_rw         <= w_rw;
                txn_slave_addr <= w_addr;
                txn_data_addr  <= w_daddr;
                txn_data       <= w_data;
                txn_nack       <= w_nack;
                txn_err        <= rec_err;
            end
            if (start_det)     busy <= 1'b1;
            else if (stop_det) busy <= 1'b0;

            if (scl_rise) begin
                bit_smp <= sda_s;
                armed   <= 1'b1;
            end

            if (start_det || stop_det) begin
                armed      <= 1'b0;
                bit_cnt    <= '0;
                shift      <= '0;
                w_rw       <= 1'b0;
                w_addr     <= '0;
                addr_done  <= 1'b0;
                daddr_seen <= 1'b0;
                w_data     <= '0;
                pay_cnt    <= '0;
                w_nack     <= 1'b0;
                w_err      <= 1'b0;
                pend_nack  <= 1'b0;
                // The data address survives only an address-only write into a repeated START
                if (!(start_det && addr_only)) w_daddr <= '0;
            end else begin
                if (scl_fall) armed <= 1'b0;
                if (ack_err)  w_err <= 1'b1;
                if (in_shift && bit_fall) begin
                    shift   <= byte_val[6:0];
                    bit_cnt <= bit_cnt + 3'd1;
                end
                if (byte_done) begin
                    if (state == ADDR) begin
                        w_addr    <= byte_val[7:1];
                        w_rw      <= byte_val[0];
                        addr_done <= 1'b1;
                    end else if (!w_rw && !daddr_seen) begin
                        w_daddr    <= byte_val;
                        daddr_seen <= 1'b1;
                    end else begin
                        if (pay_cnt < NB)     w_data  <= (w_data << 8) | DATA_WIDTH'(byte_val);
                        if (pay_cnt != 8'hFF) pay_cnt <= pay_cnt + 8'd1;
                    end
                end
                if (bit_fall && (state == ADDR_ACK) && bit_smp) w_nack <= 1'b1;
                // A read NACK only counts once a further byte proves it was not the last one
                if (bit_fall && (state == BYTE_ACK)) begin
                    if (!w_rw) begin
                        if (bit_smp) w_nack <= 1'b1;
                    end else begin
                        if (pend_nack) w_nack <= 1'b1;
                        pend_nack <= bit_smp;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_i2c_monitor.sv
// tb/tb_i2c_monitor.sv - directed self-checking bench for i2c_monitor
module tb_i2c_monitor;
    logic        clk = 1'b0;
    logic        rst;
    logic        scl, sda;
    logic        txn_valid, txn_rw, txn_nack, txn_err, busy;
    logic [6:0]  txn_slave_addr;
    logic [7:0]  txn_data_addr;
    logic [31:0] txn_data;
`ifdef I2C_MON_ADDR_FILTER_EN
    logic [6:0]  filter_addr = 7'h00;
    logic        filter_on   = 1'b0;
`endif

    int passed = 0;
    int total  = 0;
    int fails  = 0;
    int pulses = 0;
    int base;

    always #5 clk = ~clk;

    i2c_monitor #(.DATA_WIDTH(32), .SYNC_STAGES(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .scl            (scl),
        .sda            (sda),
`ifdef I2C_MON_ADDR_FILTER_EN
        .filter_addr    (filter_addr),
        .filter_on      (filter_on),
`endif
        .txn_valid      (txn_valid),
        .txn_rw         (txn_rw),
        .txn_slave_addr (txn_slave_addr),
        .txn_data_addr  (txn_data_addr),
        .txn_data       (txn_data),
        .txn_nack       (txn_nack),
        .txn_err        (txn_err),
        .busy           (busy)
    );

    always @(negedge clk) if (txn_valid) pulses++;

    task automatic wt(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_start();
        sda = 1'b1; scl = 1'b1; wt(4);
        sda = 1'b0; wt(4);
        scl = 1'b0; wt(4);
    endtask

    task automatic bus_rstart();
        sda = 1'b1; wt(4);
        scl = 1'b1; wt(4);
        sda = 1'b0; wt(4);
        scl = 1'b0; wt(4);
    endtask

    task automatic bus_stop();
        sda = 1'b0; wt(4);
        scl = 1'b1; wt(4);
        sda = 1'b1; wt(4);
    endtask

    task automatic bus_bit(input logic b);
        sda = b;    wt(4);
        scl = 1'b1; wt(4);
        scl = 1'b0; wt(4);
    endtask

    task automatic bus_byte(input logic [7:0] v, input logic ack);
        for (int i = 7; i >= 0; i--) bus_bit(v[i]);
        bus_bit(ack);
    endtask

    task automatic check_rec(input string tag, input logic rw, input logic [6:0] a,
                             input logic [7:0] da, input logic [31:0] d,
                             input logic nk, input logic er);
        check({tag, ".rw"},    txn_rw, rw);
        check({tag, ".addr"},  txn_slave_addr, a);
        check({tag, ".daddr"}, txn_data_addr, da);
        check({tag, ".data"},  txn_data, d);
        check({tag, ".nack"},  txn_nack, nk);
        check({tag, ".err"},   txn_err, er);
    endtask

    initial begin
        rst = 1'b1; scl = 1'b1; sda = 1'b1;
        wt(5);
        check("rst.valid", txn_valid, 0);
        check("rst.busy",  busy, 0);
        check_rec("rst", 0, 7'h00, 8'h00, 32'h0, 0, 0);
        rst = 1'b0;
        wt(5);

        // plain write
        base = pulses;
        bus_start();
        check("wr.busy_mid", busy, 1);
        bus_byte(8'h9A, 1'b0);
        bus_byte(8'h69, 1'b0);
        bus_byte(8'hAB, 1'b0);
        bus_byte(8'h00, 1'b0);
        bus_byte(8'h00, 1'b0);
        bus_byte(8'h01, 1'b0);
        bus_stop();
        wt(8);
        check("wr.pulses", pulses - base, 1);
        check("wr.busy_end", busy, 0);
        check_rec("wr", 0, 7'h4D, 8'h69, 32'hAB000001, 0, 0);

        // address-only write, repeated START, read with final NACK
        base = pulses;
        bus_start();
        bus_byte(8'h26, 1'b0);
        bus_byte(8'hDE, 1'b0);
        bus_rstart();
        bus_byte(8'h27, 1'b0);
        bus_byte(8'hBC, 1'b0);
        bus_byte(8'hD0, 1'b0);
        bus_byte(8'hA0, 1'b0);
        bus_byte(8'h01, 1'b1);
        bus_stop();
        wt(8);
        check("rd.pulses", pulses - base, 1);
        check_rec("rd", 1, 7'h13, 8'hDE, 32'hBCD0A001, 0, 0);

        // address not acknowledged
        base = pulses;
        bus_start();
        bus_byte(8'hA6, 1'b1);
        bus_stop();
        wt(8);
        check("anack.pulses", pulses - base, 1);
        check_rec("anack", 0, 7'h53, 8'h00, 32'h0, 1, 1);

        // STOP two bits into the third payload byte
        base = pulses;
        bus_start();
        bus_byte(8'h9A, 1'b0);
        bus_byte(8'h69, 1'b0);
        bus_byte(8'hAB, 1'b0);
        bus_byte(8'h00, 1'b0);
        bus_bit(1'b1);
        bus_bit(1'b0);
        bus_stop();
        wt(30);
        check("trunc.pulses", pulses - base, 1);
        check_rec("trunc", 0, 7'h4D, 8'h69, 32'h0000AB00, 0, 1);

        // reset in the middle of the payload
        base = pulses;
        bus_start();
        bus_byte(8'h9A, 1'b0);
        bus_byte(8'h69, 1'b0);
        bus_byte(8'hAB, 1'b0);
        bus_bit(1'b1);
        bus_bit(1'b0);
        rst = 1'b1;
        wt(3);
        check("mrst.busy", busy, 0);
        check_rec("mrst", 0, 7'h00, 8'h00, 32'h0, 0, 0);
        rst = 1'b0;
        wt(10);
        check("mrst.no_pulse", pulses - base, 0);
        bus_start();
        bus_byte(8'h9A, 1'b0);
        bus_byte(8'h69, 1'b0);
        bus_byte(8'hCD, 1'b0);
        bus_byte(8'h00, 1'b0);
        bus_byte(8'h00, 1'b0);
        bus_byte(8'h01, 1'b0);
        bus_stop();
        wt(8);
        check("post.pulses", pulses - base, 1);
        check_rec("post", 0, 7'h4D, 8'h69, 32'hCD000001, 0, 0);

`ifdef I2C_MON_ADDR_FILTER_EN
        filter_addr = 7'h13;
        filter_on   = 1'b1;
        base = pulses;
        bus_start();
        bus_byte(8'h9A, 1'b0);
        bus_byte(8'h69, 1'b0);
        bus_byte(8'h11, 1'b0);
        bus_byte(8'h22, 1'b0);
        bus_byte(8'h33, 1'b0);
        bus_byte(8'h44, 1'b0);
        bus_stop();
        wt(8);
        check("flt.drop", pulses - base, 0);
        bus_start();
        bus_byte(8'h26, 1'b0);
        bus_byte(8'h22, 1'b0);
        bus_byte(8'h11, 1'b0);
        bus_byte(8'h22, 1'b0);
        bus_byte(8'h33, 1'b0);
        bus_byte(8'h44, 1'b0);
        bus_stop();
        wt(8);
        check("flt.keep", pulses - base, 1);
        check_rec("flt", 0, 7'h13, 8'h22, 32'h11223344, 0, 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
